onehot_state_decoder: RTL and testbench

Registered consumer of the 10-bit one-hot next-state vector produced by the ALU state selector. It accepts one selection per handshake, checks it is legal one-hot, and encodes it back to a 3-bit opcode. It then holds the ALU in an execute window (multi-cycle for MULT) and reports issue and completion pulses to the datapath. Illegal vectors are counted and flagged instead of being executed.

---
 rtl/onehot_state_decoder.sv | 64 ++++++
 tb/tb_onehot_state_decoder.sv | 110 +++++++++++
 2 files changed

// File: rtl/onehot_state_decoder.sv
// onehot_state_decoder: validates a one-hot ALU next-state vector, encodes it and runs the execute window.
module onehot_state_decoder #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sel_onehot,
  input  logic       sel_valid,
  output logic       sel_ready,
  output logic [2:0] op_code,
  output logic       op_valid,
  output logic       op_busy,
  output logic       op_done,
  output logic       in_reset_state,
  output logic       illegal,
  input  logic       illegal_clr,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {INIT, IDLE, EXEC, RHOLD} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [2:0] enc;
  logic       first, legal, accept;
  assign legal  = !sel_onehot[9] && $onehot(sel_onehot[8:0]);
  assign accept = sel_valid && sel_ready;
  always_comb begin
    enc = '0;
    for (int i = 0; i < 8; i++)
      if (sel_onehot[i]) enc = 3'(i);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == EXEC ? (cnt == 0 ? IDLE : EXEC) :
               state == IDLE ? (accept && legal ? (sel_onehot[8] ? RHOLD : EXEC) : IDLE) :
               IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      first     <= 1'b0;
      op_code   <= '0;
      illegal   <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      if (accept && legal) begin
        op_code <= enc;
        cnt     <= enc == 3'd2 && !sel_onehot[8] ? 4'(MULT_CYCLES - 1) : 4'd0;
        first   <= 1'b1;
      end else if (state == EXEC) begin
        cnt   <= cnt - 4'd1;
        first <= 1'b0;
      end
      illegal <= accept && !legal ? 1'b1 : illegal_clr ? 1'b0 : illegal;
      if (accept && !legal && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
  assign sel_ready      = state == IDLE;
  assign op_busy        = state == EXEC;
  assign op_valid       = op_busy && first;
  assign op_done        = op_busy && cnt == 0;
  assign in_reset_state = state == RHOLD;
endmodule

// File: tb/tb_onehot_state_decoder.sv
// tb_onehot_state_decoder: table-driven check of accept, execute windows, illegal counting and reset abort.
module tb_onehot_state_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sel_onehot = '0;
  logic       sel_valid = 1'b0;
  logic       illegal_clr = 1'b0;
  logic       sel_ready, op_valid, op_busy, op_done, in_reset_state, illegal;
  logic [2:0] op_code;
  logic [7:0] err_count;
  logic [16:0] obs;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [9:0]  sel;
    logic        v;
    logic        clr;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[18];

  onehot_state_decoder #(.MULT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_onehot(sel_onehot), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .op_code(op_code), .op_valid(op_valid), .op_busy(op_busy),
    .op_done(op_done), .in_reset_state(in_reset_state), .illegal(illegal),
    .illegal_clr(illegal_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;
  // {ready, code, valid, busy, done, reset_state, illegal, err_count}
  assign obs = {sel_ready, op_code, op_valid, op_busy, op_done, in_reset_state, illegal, err_count};

  function automatic vec_t mk(logic [9:0] s, logic v, logic c, logic r, logic [2:0] code,
                              logic [4:0] f, logic [7:0] e);
    return '{s, v, c, {r, code, f, e}};
  endfunction

  task automatic chk(input string nm, input logic [16:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, obs, exp);
    end
  endtask

  initial begin
    vecs[0]  = mk(10'h000, 0, 0, 1, 0, 5'b00000, 0);
    vecs[1]  = mk(10'h001, 1, 0, 0, 0, 5'b11100, 0);
    vecs[2]  = mk(10'h000, 0, 0, 1, 0, 5'b00000, 0);
    vecs[3]  = mk(10'h004, 1, 0, 0, 2, 5'b11000, 0);
    vecs[4]  = mk(10'h004, 1, 0, 0, 2, 5'b01000, 0);
    vecs[5]  = mk(10'h004, 1, 0, 0, 2, 5'b01000, 0);
    vecs[6]  = mk(10'h004, 1, 0, 0, 2, 5'b01100, 0);
    vecs[7]  = mk(10'h004, 1, 0, 1, 2, 5'b00000, 0);
    vecs[8]  = mk(10'h100, 1, 0, 0, 0, 5'b00010, 0);
    vecs[9]  = mk(10'h000, 0, 0, 1, 0, 5'b00000, 0);
    vecs[10] = mk(10'h010, 1, 0, 0, 4, 5'b11100, 0);
    vecs[11] = mk(10'h000, 0, 0, 1, 4, 5'b00000, 0);
    vecs[12] = mk(10'h000, 1, 0, 1, 4, 5'b00001, 1);
    vecs[13] = mk(10'h003, 1, 0, 1, 4, 5'b00001, 2);
    vecs[14] = mk(10'h200, 1, 0, 1, 4, 5'b00001, 3);
    vecs[15] = mk(10'h081, 1, 1, 1, 4, 5'b00001, 4);
    vecs[16] = mk(10'h000, 0, 1, 1, 4, 5'b00000, 4);
    vecs[17] = mk(10'h000, 0, 0, 1, 4, 5'b00000, 4);
    #3 chk("in_reset", 17'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sel_onehot = vecs[i].sel;
      sel_valid = vecs[i].v;
      illegal_clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end
    sel_onehot = 10'h000;
    sel_valid = 1'b1;
    repeat (260) @(negedge clk);
    chk("saturate", {1'b1, 3'd4, 5'b00001, 8'd255});
    sel_valid = 1'b0;
    illegal_clr = 1'b1;
    @(negedge clk);
    chk("clr_after_sat", {1'b1, 3'd4, 5'b00000, 8'd255});
    illegal_clr = 1'b0;
    sel_onehot = 10'h004;
    sel_valid = 1'b1;
    @(negedge clk);
    chk("mult_start", {1'b0, 3'd2, 5'b11000, 8'd255});
    sel_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_abort", 17'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("held_reset%0d", i), 17'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {1'b1, 3'd0, 5'b00000, 8'd0});
    sel_onehot = 10'h002;
    sel_valid = 1'b1;
    @(negedge clk);
    chk("sub_exec", {1'b0, 3'd1, 5'b11100, 8'd0});
    sel_valid = 1'b0;
    sel_onehot = 10'h3ff;
    @(negedge clk);
    chk("sub_back_idle", {1'b1, 3'd1, 5'b00000, 8'd0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
